// File: rtl/avl_burst_slave_mem.sv
// Avalon-MM burst responder backed by on-chip RAM.
// Pipelined burst writes, fixed-latency burst reads, optional write stalls.
module avl_burst_slave_mem #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 27,
  parameter int DEPTH_LOG2   = 10,
  parameter int BURST_W      = 8,
  parameter int RD_LATENCY   = 2,
  parameter int STALL_PERIOD = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   avl_address,
  input  logic                avl_beginbursttransfer,
  input  logic [BURST_W-1:0]  avl_burstcount,
  input  logic                avl_write,
  input  logic [DATA_W-1:0]   avl_writedata,
  input  logic [DATA_W/8-1:0] avl_byteenable,
  input  logic                avl_read,
  output logic                avl_waitrequest,
  output logic [DATA_W-1:0]   avl_readdata,
  output logic                avl_readdatavalid,
  output logic                wr_burst_done,
  output logic                rd_burst_done,
  output logic                proto_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LAT   = RD_LATENCY;
  localparam logic [15:0] SP = 16'(STALL_PERIOD);

  typedef logic [DEPTH_LOG2-1:0] addr_t;
  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  state_t             state;
  addr_t              base;
  logic [BURST_W-1:0] count;
  logic [BURST_W-1:0] idx;
  logic [BURST_W-1:0] bc_eff;
  logic               wait_q;
  logic               wr_done_q;
  logic               err_q;
  logic [15:0]        stall_cnt;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [LAT-1:0]     rd_v;
  logic [LAT-1:0]     rd_l;
  logic [DATA_W-1:0]  rd_d [LAT];

  logic  bc_zero;
  logic  wr_acc;
  logic  rd_acc;
  logic  wr_last;
  logic  stall_hit;
  logic  issue_v;
  logic  issue_last;
  addr_t cmd_addr;
  addr_t wr_addr;
  addr_t issue_addr;
  logic  unused_in;

  assign unused_in = ^{avl_beginbursttransfer,
                       avl_address[ADDR_W-1:DEPTH_LOG2]};

  assign cmd_addr = avl_address[DEPTH_LOG2-1:0];
  assign bc_zero  = avl_burstcount == '0;
  assign bc_eff   = bc_zero ? BURST_W'(1) : avl_burstcount;

  // a simultaneous read+write in IDLE resolves to the write
  assign wr_acc = avl_write && !wait_q && !reset;
  assign rd_acc = avl_read && !avl_write && !wait_q &&
                  !reset && state == IDLE;

  assign stall_hit = (STALL_PERIOD > 0) && wr_acc &&
                     stall_cnt == SP - 16'd1;

  always_comb begin
    wr_addr    = cmd_addr;
    wr_last    = bc_eff == BURST_W'(1);
    issue_v    = rd_acc;
    issue_addr = cmd_addr;
    issue_last = wr_last;
    if (state != IDLE) begin
      wr_addr    = base + addr_t'(idx);
      wr_last    = idx == count - BURST_W'(1);
      issue_addr = wr_addr;
      issue_last = wr_last;
    end
    if (state == RD_BURST) begin
      issue_v = idx != count;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int k = 0; k < BE_W; k++) begin
        if (avl_byteenable[k]) begin
          mem[wr_addr][k*8 +: 8] <= avl_writedata[k*8 +: 8];
        end
      end
    end
  end

  // beat j issued j cycles after acceptance, then LAT stages to the port
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v <= '0;
      rd_l <= '0;
      for (int i = 0; i < LAT; i++) begin
        rd_d[i] <= '0;
      end
    end else begin
      rd_v[0] <= issue_v;
      rd_l[0] <= issue_v && issue_last;
      if (issue_v) begin
        rd_d[0] <= mem[issue_addr];
      end
      for (int i = 1; i < LAT; i++) begin
        rd_v[i] <= rd_v[i-1];
        rd_l[i] <= rd_l[i-1];
        if (rd_v[i-1]) begin
          rd_d[i] <= rd_d[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      base      <= '0;
      count     <= '0;
      idx       <= '0;
      wait_q    <= 1'b0;
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      wr_done_q <= 1'b0;
      wait_q    <= stall_hit;
      if (wr_acc) begin
        stall_cnt <= stall_hit ? '0 : stall_cnt + 16'd1;
      end
      unique case (state)
        IDLE: begin
          if (wr_acc) begin
            base  <= cmd_addr;
            count <= bc_eff;
            idx   <= BURST_W'(1);
            if (avl_read || bc_zero) begin
              err_q <= 1'b1;
            end
            if (wr_last) begin
              wr_done_q <= 1'b1;
            end else begin
              state <= WR_BURST;
            end
          end else if (rd_acc) begin
            base   <= cmd_addr;
            count  <= bc_eff;
            idx    <= BURST_W'(1);
            state  <= RD_BURST;
            wait_q <= 1'b1;
            if (bc_zero) begin
              err_q <= 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (avl_read) begin
            err_q <= 1'b1;
          end
          if (wr_acc) begin
            idx <= idx + BURST_W'(1);
            if (wr_last) begin
              wr_done_q <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        RD_BURST: begin
          wait_q <= 1'b1;
          if (idx != count) begin
            idx <= idx + BURST_W'(1);
          end
          if (rd_v[LAT-1] && rd_l[LAT-1]) begin
            state  <= IDLE;
            wait_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign avl_waitrequest   = wait_q | reset;
  assign avl_readdata      = rd_d[LAT-1];
  assign avl_readdatavalid = rd_v[LAT-1] & ~reset;
  assign rd_burst_done     = rd_v[LAT-1] & rd_l[LAT-1] & ~reset;
  assign wr_burst_done     = wr_done_q;
  assign proto_err         = err_q;

endmodule

// File: tb/tb_avl_burst_slave_mem.sv
// Directed bench for avl_burst_slave_mem.
// Two instances: no stalls, and stall after every 4 write beats.
module tb_avl_burst_slave_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [26:0] avl_address;
  logic        avl_beginbursttransfer;
  logic [7:0]  avl_burstcount;
  logic        avl_write;
  logic [63:0] avl_writedata;
  logic [7:0]  avl_byteenable;
  logic        avl_read;

  logic        avl_waitrequest;
  logic [63:0] avl_readdata;
  logic        avl_readdatavalid;
  logic        wr_burst_done;
  logic        rd_burst_done;
  logic        proto_err;

  logic        wait_s;
  logic [63:0] rdata_s;
  logic        rv_s;
  logic        wdone_s;
  logic        rdone_s;
  logic        err_s;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_done_cnt = 0;

  always #5 clk = ~clk;

  avl_burst_slave_mem dut (
    .clk                    (clk),
    .reset                  (reset),
    .avl_address            (avl_address),
    .avl_beginbursttransfer (avl_beginbursttransfer),
    .avl_burstcount         (avl_burstcount),
    .avl_write              (avl_write),
    .avl_writedata          (avl_writedata),
    .avl_byteenable         (avl_byteenable),
    .avl_read               (avl_read),
    .avl_waitrequest        (avl_waitrequest),
    .avl_readdata           (avl_readdata),
    .avl_readdatavalid      (avl_readdatavalid),
    .wr_burst_done          (wr_burst_done),
    .rd_burst_done          (rd_burst_done),
    .proto_err              (proto_err)
  );

  avl_burst_slave_mem #(.STALL_PERIOD(4)) dut_s (
    .clk                    (clk),
    .reset                  (reset),
    .avl_address            (avl_address),
    .avl_beginbursttransfer (avl_beginbursttransfer),
    .avl_burstcount         (avl_burstcount),
    .avl_write              (avl_write),
    .avl_writedata          (avl_writedata),
    .avl_byteenable         (avl_byteenable),
    .avl_read               (avl_read),
    .avl_waitrequest        (wait_s),
    .avl_readdata           (rdata_s),
    .avl_readdatavalid      (rv_s),
    .wr_burst_done          (wdone_s),
    .rd_burst_done          (rdone_s),
    .proto_err              (err_s)
  );

  always @(negedge clk) begin
    if (wr_burst_done) wr_done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input logic [26:0] a, input int n,
                             input logic [63:0] d0, input logic [7:0] be,
                             input int gap, input string tag);
    int  i = 0;
    int  cyc = 0;
    logic acc;
    avl_address = a;
    avl_burstcount = n[7:0];
    avl_byteenable = be;
    avl_beginbursttransfer = 1'b1;
    while (i < n && cyc < 1000) begin
      avl_write = !(gap != 0 && (cyc % gap) == gap - 1);
      avl_writedata = d0 + 64'(i);
      #3;
      acc = avl_write && !avl_waitrequest;
      step();
      avl_beginbursttransfer = 1'b0;
      if (acc) i++;
      cyc++;
    end
    avl_write = 1'b0;
    check({tag, "_beats"}, 64'(i), 64'(n));
  endtask

  task automatic read_burst(input logic [26:0] a, input int n,
                            input logic [63:0] d0, input bit s,
                            input string tag);
    int   got = 0;
    int   cyc = 0;
    int   first = -1;
    int   last = -1;
    int   bad_done = 0;
    logic v, dn, wq;
    logic [63:0] d;
    avl_read = 1'b1;
    avl_address = a;
    avl_burstcount = n[7:0];
    #3;
    wq = s ? wait_s : avl_waitrequest;
    check({tag, "_cmd_wait"}, 64'(wq), 64'(0));
    step();
    avl_read = 1'b0;
    while (got < n && cyc < n + 20) begin
      @(negedge clk);
      cyc++;
      v  = s ? rv_s : avl_readdatavalid;
      dn = s ? rdone_s : rd_burst_done;
      d  = s ? rdata_s : avl_readdata;
      wq = s ? wait_s : avl_waitrequest;
      if (cyc == 1) check({tag, "_busy"}, 64'(wq), 64'(1));
      if (v) begin
        if (first < 0) first = cyc;
        last = cyc;
        check({tag, "_data"}, d, d0 + 64'(got));
        if (dn != (got == n - 1)) bad_done++;
        got++;
      end else if (dn) begin
        bad_done++;
      end
    end
    check({tag, "_count"}, 64'(got), 64'(n));
    check({tag, "_first_lat"}, 64'(first), 64'(2));
    check({tag, "_last_lat"}, 64'(last), 64'(n + 1));
    check({tag, "_done_pulse"}, 64'(bad_done), 64'(0));
    @(negedge clk);
    wq = s ? wait_s : avl_waitrequest;
    check({tag, "_wait_drop"}, 64'(wq), 64'(0));
    step();
  endtask

  initial begin
    int   cnt0;
    int   nv;
    int   beats;
    logic acc;
    logic [10:0] wpat;
    logic [10:0] dpat;

    reset = 1'b1;
    avl_address = '0;
    avl_beginbursttransfer = 1'b0;
    avl_burstcount = '0;
    avl_write = 1'b0;
    avl_writedata = '0;
    avl_byteenable = '0;
    avl_read = 1'b0;

    step();
    step();
    #3;
    check("rst_wait", 64'(avl_waitrequest), 64'(1));
    check("rst_rvalid", 64'(avl_readdatavalid), 64'(0));
    check("rst_rdata", avl_readdata, 64'(0));
    check("rst_wdone", 64'(wr_burst_done), 64'(0));
    check("rst_rdone", 64'(rd_burst_done), 64'(0));
    check("rst_err", 64'(proto_err), 64'(0));
    step();
    reset = 1'b0;
    #3;
    check("post_rst_wait", 64'(avl_waitrequest), 64'(0));
    step();

    cnt0 = wr_done_cnt;
    write_burst(27'd0, 128, 64'd0, 8'hFF, 0, "w128");
    read_burst(27'd0, 128, 64'd0, 1'b0, "r128");
    check("w128_done_cnt", 64'(wr_done_cnt - cnt0), 64'(1));
    check("r128_err", 64'(proto_err), 64'(0));

    cnt0 = wr_done_cnt;
    write_burst(27'd128, 96, 64'd0, 8'hFF, 3, "w96gap");
    read_burst(27'd128, 96, 64'd0, 1'b0, "r96");
    check("w96_done_cnt", 64'(wr_done_cnt - cnt0), 64'(1));

    write_burst(27'd5, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, "wff");
    write_burst(27'd5, 1, 64'd0, 8'h0F, 0, "wbe");
    read_burst(27'd5, 1, 64'hFFFF_FFFF_0000_0000, 1'b0, "rbe");

    write_burst(27'd1022, 4, 64'hA, 8'hFF, 0, "wwrap");
    read_burst(27'd1022, 4, 64'hA, 1'b0, "rwrap");
    read_burst(27'd0, 2, 64'hC, 1'b0, "rwrap_low");

    avl_read = 1'b1;
    avl_address = 27'd0;
    avl_burstcount = 8'd16;
    step();
    avl_read = 1'b0;
    step();
    #3;
    check("mid_beat0_valid", 64'(avl_readdatavalid), 64'(1));
    step();
    reset = 1'b1;
    #3;
    check("mid_rst_rvalid", 64'(avl_readdatavalid), 64'(0));
    check("mid_rst_wait", 64'(avl_waitrequest), 64'(1));
    check("mid_rst_rdone", 64'(rd_burst_done), 64'(0));
    step();
    reset = 1'b0;
    #3;
    check("mid_rel_wait", 64'(avl_waitrequest), 64'(0));
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (avl_readdatavalid) nv++;
    end
    check("mid_no_stale", 64'(nv), 64'(0));
    step();
    read_burst(27'd10, 4, 64'd10, 1'b0, "r_after_rst");

    avl_write = 1'b1;
    avl_read = 1'b1;
    avl_address = 27'd7;
    avl_burstcount = 8'd1;
    avl_writedata = 64'h55;
    avl_byteenable = 8'hFF;
    step();
    avl_write = 1'b0;
    avl_read = 1'b0;
    #3;
    check("rw_err", 64'(proto_err), 64'(1));
    check("rw_wdone", 64'(wr_burst_done), 64'(1));
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (avl_readdatavalid) nv++;
    end
    check("rw_no_rvalid", 64'(nv), 64'(0));
    step();
    read_burst(27'd7, 1, 64'h55, 1'b0, "rw_rd");
    check("rw_err_sticky", 64'(proto_err), 64'(1));

    reset = 1'b1;
    step();
    reset = 1'b0;
    #3;
    check("err_cleared", 64'(proto_err), 64'(0));
    avl_write = 1'b1;
    avl_address = 27'd9;
    avl_burstcount = 8'd0;
    avl_writedata = 64'h99;
    step();
    avl_write = 1'b0;
    #3;
    check("bc0_err", 64'(proto_err), 64'(1));
    check("bc0_wdone", 64'(wr_burst_done), 64'(1));
    check("bc0_idle", 64'(avl_waitrequest), 64'(0));
    step();
    read_burst(27'd9, 1, 64'h99, 1'b0, "bc0_rd");

    reset = 1'b1;
    step();
    reset = 1'b0;
    beats = 0;
    wpat = '0;
    dpat = '0;
    avl_address = 27'd400;
    avl_burstcount = 8'd8;
    avl_byteenable = 8'hFF;
    for (int c = 0; c < 11; c++) begin
      avl_write = beats < 8;
      avl_writedata = 64'h100 + 64'(beats);
      #3;
      wpat[c] = wait_s;
      dpat[c] = wdone_s;
      acc = avl_write && !wait_s;
      step();
      if (acc) beats++;
    end
    avl_write = 1'b0;
    check("stall_beats", 64'(beats), 64'(8));
    check("stall_wait_pat", 64'(wpat), 64'(11'h210));
    check("stall_wdone_pat", 64'(dpat), 64'(11'h200));
    read_burst(27'd400, 8, 64'h100, 1'b1, "stall_rd");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/avl_burst_slave_mem.md
Name: avl_burst_slave_mem

Overview:
Avalon-MM burst responder backed by on-chip RAM. It models the external SDRAM controller port that the concat buffer master drives, so concat write and read-back traffic can run in simulation and in on-chip-only builds. It accepts pipelined burst writes and burst reads (bursts of 128 and 96 beats of 64-bit words, among others) and returns read data with fixed latency. It can also insert periodic waitrequest stalls to stress the master.

Parameters:
DATA_W, 64, data bus width; byteenable width is DATA_W/8.
ADDR_W, 27, Avalon word-address width.
DEPTH_LOG2, 10, log2 of RAM depth in words; only avl_address[DEPTH_LOG2-1:0] is used.
BURST_W, 8, burstcount width.
RD_LATENCY, 2, cycles from read-command acceptance to first avl_readdatavalid; legal range 1..4.
STALL_PERIOD, 0, 0 = never stall; N>0 = one forced waitrequest cycle after every N accepted write beats.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
avl_address  in  ADDR_W  word address; sampled only on command acceptance
avl_beginbursttransfer  in  1  informational only; not used for decode
avl_burstcount  in  BURST_W  beats in burst; sampled on command acceptance
avl_write  in  1  write request / write beat valid
avl_writedata  in  DATA_W  write data
avl_byteenable  in  DATA_W/8  per-byte write enable
avl_read  in  1  read command
avl_waitrequest  out  1  1 = transfer not accepted this cycle
avl_readdata  out  DATA_W  read data
avl_readdatavalid  out  1  readdata valid
wr_burst_done  out  1  one-cycle pulse after last write beat is accepted
rd_burst_done  out  1  one-cycle pulse with last readdatavalid
proto_err  out  1  sticky protocol-error flag; cleared only by reset

Behaviour:
- Reset, synchronous: FSM=IDLE, counters=0. avl_waitrequest=1 while reset is high, then 0 on the first cycle after reset in IDLE. avl_readdatavalid=0, avl_readdata=0, done pulses=0, proto_err=0. RAM contents are not cleared.
- FSM states: IDLE, WR_BURST, RD_BURST.
- Acceptance rule: a transfer is accepted on any cycle with (write or read) and avl_waitrequest=0.
- IDLE + accepted write:
  - Latch base=address[DEPTH_LOG2-1:0] and remaining=burstcount. Write beat 0 to base.
  - If burstcount=1, pulse wr_burst_done next cycle and stay in IDLE. Otherwise go to WR_BURST.
- WR_BURST:
  - Each accepted write beat i stores to (base+i) mod 2^DEPTH_LOG2; address and burstcount are ignored.
  - A cycle with write=0 is a gap: no store, counter holds.
  - After the last beat, wr_burst_done pulses next cycle and the FSM returns to IDLE.
  - read=1 during WR_BURST sets proto_err and is ignored.
- Byte lanes: byte k is written only if byteenable[k]=1; other bytes keep their old value.
- IDLE + accepted read: latch base and count, go to RD_BURST. avl_waitrequest=1 for the entire RD_BURST; no new commands are accepted during a read.
- Read data timing:
  - Word j (j=0..count-1) appears with avl_readdatavalid=1 exactly RD_LATENCY+j cycles after the acceptance cycle, one word per cycle with no gaps.
  - The address wraps mod depth.
  - rd_burst_done coincides with the last valid beat. The FSM returns to IDLE the cycle after the last beat, and avl_waitrequest drops in that cycle.
- Read-after-write: a read accepted the cycle after the final write beat returns the newly written data. The RAM is write-first, or the RAM has a bypass.
- Both read and write high in IDLE: the write is accepted and executed, the read is ignored, and proto_err=1.
- burstcount=0 on acceptance: treated as 1 and proto_err=1.
- Stall injection, STALL_PERIOD=N>0: after every Nth accepted write beat (counted across bursts), avl_waitrequest=1 for exactly one cycle. The beat presented in that cycle is not accepted and must be held by the master.
- Reset mid-burst: the FSM returns to IDLE immediately and pending read beats are discarded (readdatavalid=0 from the reset cycle on). Writes already accepted remain in RAM.
- avl_readdata holds its last value when avl_readdatavalid=0.

Test Plan:
- Burst write 128 beats at addr 0, data=i, byteenable=FF, then burst read 128 at addr 0 -> first readdatavalid at cycle accept+2; data 0..127 contiguous; rd_burst_done on beat 127; proto_err=0.
- Burst write 96 beats at addr 128 with write deasserted every 3rd cycle -> gaps do not advance the counter; read-back of addr 128..223 returns data 0..95; wr_burst_done pulses once.
- Write FFFF_FFFF_FFFF_FFFF to addr 5, then write 0 to addr 5 with byteenable=0x0F -> read returns FFFF_FFFF_0000_0000.
- DEPTH_LOG2=10: write a 4-beat burst at addr 1022 with data A,B,C,D -> RAM addr 1022,1023,0,1 hold A,B,C,D; a 4-beat read at 1022 returns A,B,C,D.
- Assert reset 3 cycles after accepting a 16-beat read -> readdatavalid=0 from the reset cycle; waitrequest=1 during reset and 0 the cycle after reset releases; a subsequent read returns correct data.
- read=write=1 in IDLE with addr 7, data 0x55 -> proto_err=1; addr 7 holds 0x55; no readdatavalid. STALL_PERIOD=4 with an 8-beat write -> waitrequest high exactly one cycle after beats 4 and 8.
